mba_sram_port_arb: RTL and testbench
====================================

Name: mba_sram_port_arb

Overview:
- Two-requester arbiter sharing the single RW port (port 0) of the 2 KB 1rw1r SRAM macro exposed on the mba_mem_* pins.
- Requester 0 is the instruction fetch port (read-only); requester 1 is the data port (read/write, byte enables).
- Issues one SRAM access per cycle and returns read data with the macro's 1-cycle latency. Tags each response to the requester that issued it.
- Data port has priority; a starvation counter guarantees instruction forward progress.

Parameters:
- ADDR_WIDTH, 15, byte-address width of requester ports
- DATA_WIDTH, 32, data width; fixed to 32 by the macro
- MAX_WAIT, 4, consecutive cycles instr may be denied before it is forced to win (1..15)

Ports:
- clk  in  1  clock
- rstn_i  in  1  asynchronous active-low reset
- instr_req_i  in  1  instr request
- instr_gnt_o  out  1  instr request accepted this cycle
- instr_addr_i  in  ADDR_WIDTH  instr byte address
- instr_rvalid_o  out  1  instr read data valid
- instr_rdata_o  out  32  instr read data
- data_req_i  in  1  data request
- data_gnt_o  out  1  data request accepted this cycle
- data_we_i  in  1  1 = write
- data_be_i  in  4  byte enables
- data_addr_i  in  ADDR_WIDTH  data byte address
- data_wdata_i  in  32  write data
- data_rvalid_o  out  1  data response valid (reads and writes)
- data_rdata_o  out  32  data read data
- mba_mem_csb0_o  out  1  port0 chip select, active-low
- mba_mem_web0_o  out  1  port0 write enable, active-low
- mba_mem_wmask0_o  out  4  port0 byte mask
- mba_mem_addr0_o  out  32  port0 word address
- mba_mem_din0_o  out  32  port0 write data
- mba_mem_dout0_i  in  32  port0 read data, valid the cycle after the access
- mba_mem_csb1_o  out  1  port1 chip select; tied 1
- mba_mem_addr1_o  out  32  port1 address; tied 0
- starve_o  out  1  high in cycles where instr wins by starvation override

Behaviour:
- Reset (rstn_i low, async): starve counter = 0, rsp_owner = NONE, both rvalid = 0, both gnt = 0, csb0 = 1, web0 = 1, wmask0 = 0, addr0 = 0, din0 = 0. Requests are ignored while reset is asserted.
- Request/grant: gnt is combinational in the request cycle. A requester holds req and its attributes stable until gnt.
- At most one gnt per cycle.
- Arbitration:
  - Data wins if data_req_i and starve_cnt < MAX_WAIT.
  - Instr wins if instr_req_i and (!data_req_i or starve_cnt == MAX_WAIT).
- starve_cnt:
  - Increments (saturating at MAX_WAIT) in cycles where instr_req_i is high and instr is not granted.
  - Clears to 0 on instr grant or when instr_req_i is low.
- starve_o = instr granted while data_req_i is high.
- Macro drive in the grant cycle (combinational):
  - csb0 = 0.
  - addr0 = zero-extend(addr[ADDR_WIDTH-1:2]).
  - Instr grant: web0 = 1, wmask0 = 0, din0 = 0.
  - Data grant: web0 = ~data_we_i, wmask0 = data_be_i, din0 = data_wdata_i.
- With no grant: csb0 = 1, web0 = 1, wmask0 = 0, addr0 = 0, din0 = 0.
- Write with data_be_i = 0: still granted and acked; wmask0 = 0, so no bytes change.
- Response: rsp_owner is registered on each grant (INSTR, DATA, or NONE).
  - The next cycle, the owner's rvalid = 1 and its rdata = mba_mem_dout0_i.
  - The other port's rdata is held at 0.
  - Data writes also produce data_rvalid_o (rdata = 0). Instr writes do not exist.
- Throughput: back-to-back grants every cycle; response N is concurrent with grant N+1; no stall.
- Address bits [1:0] are ignored; misaligned access is not the arbiter's concern.
- Address bits above the macro's 9 word bits are passed through; the SoC address map guarantees the range.
- Reset asserted mid-access: outstanding response is discarded; no rvalid after release.

Test Plan:
- Reset: hold rstn_i low with both reqs high -> csb0 = 1, both gnt = 0, both rvalid = 0. After release, first edge grants data.
- Single read: preload word 0x10 = 0xDEADBEEF; instr_req, addr 0x040 -> instr_gnt same cycle, addr0 = 0x10, web0 = 1. Next cycle instr_rvalid = 1, rdata = 0xDEADBEEF; data_rvalid = 0.
- Byte write then read: data write be = 4'b0010, wdata = 0x0000AB00, addr 0x044 over existing 0x11223344 -> web0 = 0, wmask0 = 0010, data_rvalid next cycle. Readback = 0x1122AB44.
- Starvation, MAX_WAIT = 4: both reqs held continuously -> grant sequence D,D,D,D,I,D,D,D,D,I. starve_o is high only on I cycles.
- Back-to-back mixed: D-read, I-read, D-write on consecutive cycles -> rvalid pulses route D, I, D on consecutive cycles with correct data; csb0 low for 3 cycles.
- Mid-access reset: grant an instr read, assert rstn_i in the following cycle -> no instr_rvalid is produced; outputs hold reset values.

Source files
------------

// File: rtl/mba_sram_port_arb.sv
// Two-requester arbiter for the single RW port of the 1rw1r SRAM macro.
// Data port has priority; a starvation counter forces instruction fetch through.
module mba_sram_port_arb #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  rstn_i,
  input  logic                  instr_req_i,
  output logic                  instr_gnt_o,
  input  logic [ADDR_WIDTH-1:0] instr_addr_i,
  output logic                  instr_rvalid_o,
  output logic [DATA_WIDTH-1:0] instr_rdata_o,
  input  logic                  data_req_i,
  output logic                  data_gnt_o,
  input  logic                  data_we_i,
  input  logic [3:0]            data_be_i,
  input  logic [ADDR_WIDTH-1:0] data_addr_i,
  input  logic [DATA_WIDTH-1:0] data_wdata_i,
  output logic                  data_rvalid_o,
  output logic [DATA_WIDTH-1:0] data_rdata_o,
  output logic                  mba_mem_csb0_o,
  output logic                  mba_mem_web0_o,
  output logic [3:0]            mba_mem_wmask0_o,
  output logic [31:0]           mba_mem_addr0_o,
  output logic [31:0]           mba_mem_din0_o,
  input  logic [31:0]           mba_mem_dout0_i,
  output logic                  mba_mem_csb1_o,
  output logic [31:0]           mba_mem_addr1_o,
  output logic                  starve_o
);

  // Handshake: a requester raises req with stable attributes and holds them
  // until gnt, which is combinational in that same cycle; the response
  // (rvalid/rdata) follows exactly one cycle after the gnt.

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_INSTR = 2'd1,
    OWN_DATA  = 2'd2
  } owner_t;

  localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

  logic [3:0]            starve_cnt;
  owner_t                rsp_owner;
  logic                  rsp_we;
  logic                  instr_win;
  logic                  data_win;
  logic [ADDR_WIDTH-3:0] instr_word;
  logic [ADDR_WIDTH-3:0] data_word;
  logic                  unused_addr_bits;

  assign instr_word       = instr_addr_i[ADDR_WIDTH-1:2];
  assign data_word        = data_addr_i[ADDR_WIDTH-1:2];
  assign unused_addr_bits = ^{instr_addr_i[1:0], data_addr_i[1:0]};

  // Requests are masked while reset is held so nothing reaches the macro.
  always_comb begin
    data_win  = rstn_i && data_req_i && (starve_cnt < MAX_CNT);
    instr_win = rstn_i && instr_req_i && (!data_req_i || (starve_cnt == MAX_CNT));
  end

  assign instr_gnt_o = instr_win;
  assign data_gnt_o  = data_win;
  assign starve_o    = instr_win && data_req_i;

  always_comb begin
    mba_mem_csb0_o   = 1'b1;
    mba_mem_web0_o   = 1'b1;
    mba_mem_wmask0_o = 4'b0000;
    mba_mem_addr0_o  = 32'd0;
    mba_mem_din0_o   = 32'd0;
    if (instr_win) begin
      mba_mem_csb0_o  = 1'b0;
      mba_mem_addr0_o = 32'(instr_word);
    end else if (data_win) begin
      mba_mem_csb0_o   = 1'b0;
      mba_mem_web0_o   = ~data_we_i;
      mba_mem_wmask0_o = data_be_i;
      mba_mem_addr0_o  = 32'(data_word);
      mba_mem_din0_o   = data_wdata_i;
    end
  end

  assign mba_mem_csb1_o  = 1'b1;
  assign mba_mem_addr1_o = 32'd0;

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      starve_cnt <= 4'd0;
      rsp_owner  <= OWN_NONE;
      rsp_we     <= 1'b0;
    end else begin
      if (instr_win || !instr_req_i) begin
        starve_cnt <= 4'd0;
      end else if (starve_cnt < MAX_CNT) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
      if (instr_win) begin
        rsp_owner <= OWN_INSTR;
      end else if (data_win) begin
        rsp_owner <= OWN_DATA;
      end else begin
        rsp_owner <= OWN_NONE;
      end
      rsp_we <= data_win && data_we_i;
    end
  end

  // Write acks carry no data, so their rdata stays zero like the idle port.
  assign instr_rvalid_o = (rsp_owner == OWN_INSTR);
  assign data_rvalid_o  = (rsp_owner == OWN_DATA);
  assign instr_rdata_o  = instr_rvalid_o ? mba_mem_dout0_i : '0;
  assign data_rdata_o   = (data_rvalid_o && !rsp_we) ? mba_mem_dout0_i : '0;

endmodule

// File: tb/tb_mba_sram_port_arb.sv
// Directed bench for mba_sram_port_arb with a behavioural model of the SRAM port 0.
module tb_mba_sram_port_arb;

  logic        clk;
  logic        rstn_i;
  logic        instr_req_i;
  logic        instr_gnt_o;
  logic [14:0] instr_addr_i;
  logic        instr_rvalid_o;
  logic [31:0] instr_rdata_o;
  logic        data_req_i;
  logic        data_gnt_o;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [14:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        mba_mem_csb0_o;
  logic        mba_mem_web0_o;
  logic [3:0]  mba_mem_wmask0_o;
  logic [31:0] mba_mem_addr0_o;
  logic [31:0] mba_mem_din0_o;
  logic [31:0] mba_mem_dout0_i;
  logic        mba_mem_csb1_o;
  logic [31:0] mba_mem_addr1_o;
  logic        starve_o;

  int n_vec;
  int n_err;

  mba_sram_port_arb #(.ADDR_WIDTH(15), .DATA_WIDTH(32), .MAX_WAIT(4)) dut (
    .clk              (clk),
    .rstn_i           (rstn_i),
    .instr_req_i      (instr_req_i),
    .instr_gnt_o      (instr_gnt_o),
    .instr_addr_i     (instr_addr_i),
    .instr_rvalid_o   (instr_rvalid_o),
    .instr_rdata_o    (instr_rdata_o),
    .data_req_i       (data_req_i),
    .data_gnt_o       (data_gnt_o),
    .data_we_i        (data_we_i),
    .data_be_i        (data_be_i),
    .data_addr_i      (data_addr_i),
    .data_wdata_i     (data_wdata_i),
    .data_rvalid_o    (data_rvalid_o),
    .data_rdata_o     (data_rdata_o),
    .mba_mem_csb0_o   (mba_mem_csb0_o),
    .mba_mem_web0_o   (mba_mem_web0_o),
    .mba_mem_wmask0_o (mba_mem_wmask0_o),
    .mba_mem_addr0_o  (mba_mem_addr0_o),
    .mba_mem_din0_o   (mba_mem_din0_o),
    .mba_mem_dout0_i  (mba_mem_dout0_i),
    .mba_mem_csb1_o   (mba_mem_csb1_o),
    .mba_mem_addr1_o  (mba_mem_addr1_o),
    .starve_o         (starve_o)
  );

  // Clock: 10 time-unit period, inputs change 1 unit after posedge,
  // outputs are checked on the negedge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM port 0 model: 512 words, 1-cycle read latency, byte-masked writes.
  logic [31:0] mem [0:511];
  always @(posedge clk) begin
    if (!mba_mem_csb0_o) begin
      if (!mba_mem_web0_o) begin
        for (int b = 0; b < 4; b++) begin
          if (mba_mem_wmask0_o[b]) mem[mba_mem_addr0_o[8:0]][8*b +: 8] <= mba_mem_din0_o[8*b +: 8];
        end
      end else begin
        mba_mem_dout0_i <= mem[mba_mem_addr0_o[8:0]];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic ireq, input logic [14:0] iaddr,
                       input logic dreq, input logic dwe, input logic [3:0] dbe,
                       input logic [14:0] daddr, input logic [31:0] dwdata);
    instr_req_i  = ireq;
    instr_addr_i = iaddr;
    data_req_i   = dreq;
    data_we_i    = dwe;
    data_be_i    = dbe;
    data_addr_i  = daddr;
    data_wdata_i = dwdata;
  endtask

  // Advance to the next cycle's input slot.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    mba_mem_dout0_i = 32'd0;
    for (int i = 0; i < 512; i++) mem[i] = 32'd0;
    mem[2]    = 32'h600DCAFE;
    mem[9'h10] = 32'hDEADBEEF;
    mem[9'h11] = 32'h11223344;
    mem[9'h20] = 32'hA5A50001;
    mem[9'h21] = 32'h12345678;
    mem[9'h1FF] = 32'h0F0F0F0F;

    // Reset held with both requests high: nothing granted, macro idle.
    rstn_i = 1'b0;
    drive(1'b1, 15'h0008, 1'b1, 1'b0, 4'hF, 15'h0000, 32'd0);
    @(negedge clk);
    check("rst_csb0",   {31'd0, mba_mem_csb0_o}, 32'd1);
    check("rst_web0",   {31'd0, mba_mem_web0_o}, 32'd1);
    check("rst_gnt",    {30'd0, instr_gnt_o, data_gnt_o}, 32'd0);
    check("rst_rvalid", {30'd0, instr_rvalid_o, data_rvalid_o}, 32'd0);
    check("rst_addr0",  mba_mem_addr0_o, 32'd0);
    check("tie_port1",  {mba_mem_csb1_o, mba_mem_addr1_o[30:0]}, 32'h80000000);

    // Release with both requests held: D,D,D,D,I,D,D,D,D,I.
    next_cycle();
    rstn_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      logic exp_i;
      exp_i = (i == 4) || (i == 9);
      @(negedge clk);
      check($sformatf("stv_gnt%0d", i), {30'd0, instr_gnt_o, data_gnt_o}, exp_i ? 32'd2 : 32'd1);
      check($sformatf("stv_flag%0d", i), {31'd0, starve_o}, {31'd0, exp_i});
      if (i < 9) next_cycle();
    end
    next_cycle();
    drive(1'b0, 15'h0, 1'b0, 1'b0, 4'h0, 15'h0, 32'd0);
    @(negedge clk);
    check("stv_irsp_v", {30'd0, instr_rvalid_o, data_rvalid_o}, 32'd2);
    check("stv_irsp_d", instr_rdata_o, 32'h600DCAFE);
    check("idle_csb0",  {31'd0, mba_mem_csb0_o}, 32'd1);

    // Single instruction read of word 0x10.
    next_cycle();
    drive(1'b1, 15'h0040, 1'b0, 1'b0, 4'h0, 15'h0, 32'd0);
    @(negedge clk);
    check("rd_gnt",   {30'd0, instr_gnt_o, data_gnt_o}, 32'd2);
    check("rd_addr0", mba_mem_addr0_o, 32'h10);
    check("rd_ctl",   {28'd0, mba_mem_csb0_o, mba_mem_web0_o, starve_o, 1'b0}, 32'h4);
    next_cycle();
    drive(1'b0, 15'h0, 1'b0, 1'b0, 4'h0, 15'h0, 32'd0);
    @(negedge clk);
    check("rd_rvalid", {30'd0, instr_rvalid_o, data_rvalid_o}, 32'd2);
    check("rd_rdata",  instr_rdata_o, 32'hDEADBEEF);
    check("rd_drdata", data_rdata_o, 32'd0);

    // Byte write into word 0x11, then read it back.
    next_cycle();
    drive(1'b0, 15'h0, 1'b1, 1'b1, 4'b0010, 15'h0044, 32'h0000AB00);
    @(negedge clk);
    check("bw_gnt",   {30'd0, instr_gnt_o, data_gnt_o}, 32'd1);
    check("bw_ctl",   {27'd0, mba_mem_csb0_o, mba_mem_web0_o, 1'b0, 2'b00}, 32'd0);
    check("bw_mask",  {28'd0, mba_mem_wmask0_o}, 32'h2);
    check("bw_din",   mba_mem_din0_o, 32'h0000AB00);
    check("bw_addr0", mba_mem_addr0_o, 32'h11);
    next_cycle();
    drive(1'b0, 15'h0, 1'b1, 1'b0, 4'hF, 15'h0044, 32'd0);
    @(negedge clk);
    check("bw_ack",   {30'd0, instr_rvalid_o, data_rvalid_o}, 32'd1);
    check("bw_ackd",  data_rdata_o, 32'd0);
    check("br_web0",  {31'd0, mba_mem_web0_o}, 32'd1);
    next_cycle();
    drive(1'b0, 15'h0, 1'b0, 1'b0, 4'h0, 15'h0, 32'd0);
    @(negedge clk);
    check("br_rvalid", {30'd0, instr_rvalid_o, data_rvalid_o}, 32'd1);
    check("br_rdata",  data_rdata_o, 32'h1122AB44);

    // Back-to-back: D-read 0x20, I-read 0x21, D-write 0x22.
    next_cycle();
    drive(1'b0, 15'h0, 1'b1, 1'b0, 4'hF, 15'h0080, 32'd0);
    @(negedge clk);
    check("bb0_csb0", {31'd0, mba_mem_csb0_o}, 32'd0);
    check("bb0_gnt",  {30'd0, instr_gnt_o, data_gnt_o}, 32'd1);
    next_cycle();
    drive(1'b1, 15'h0084, 1'b0, 1'b0, 4'h0, 15'h0, 32'd0);
    @(negedge clk);
    check("bb1_csb0", {31'd0, mba_mem_csb0_o}, 32'd0);
    check("bb1_gnt",  {30'd0, instr_gnt_o, data_gnt_o}, 32'd2);
    check("bb1_rv",   {30'd0, instr_rvalid_o, data_rvalid_o}, 32'd1);
    check("bb1_rd",   data_rdata_o, 32'hA5A50001);
    next_cycle();
    drive(1'b0, 15'h0, 1'b1, 1'b1, 4'hF, 15'h0088, 32'hCAFEF00D);
    @(negedge clk);
    check("bb2_csb0", {31'd0, mba_mem_csb0_o}, 32'd0);
    check("bb2_gnt",  {30'd0, instr_gnt_o, data_gnt_o}, 32'd1);
    check("bb2_rv",   {30'd0, instr_rvalid_o, data_rvalid_o}, 32'd2);
    check("bb2_rd",   instr_rdata_o, 32'h12345678);
    check("bb2_drd",  data_rdata_o, 32'd0);
    next_cycle();
    drive(1'b0, 15'h0, 1'b0, 1'b0, 4'h0, 15'h0, 32'd0);
    @(negedge clk);
    check("bb3_csb0", {31'd0, mba_mem_csb0_o}, 32'd1);
    check("bb3_rv",   {30'd0, instr_rvalid_o, data_rvalid_o}, 32'd1);
    check("bb3_rd",   data_rdata_o, 32'd0);
    check("bb3_irdz", instr_rdata_o, 32'd0);
    check("bb_mem",   mem[9'h22], 32'hCAFEF00D);

    // Write with no byte enables: granted and acked, memory unchanged.
    next_cycle();
    drive(1'b0, 15'h0, 1'b1, 1'b1, 4'h0, 15'h0088, 32'hFFFFFFFF);
    @(negedge clk);
    check("z_gnt",  {30'd0, instr_gnt_o, data_gnt_o}, 32'd1);
    check("z_mask", {27'd0, mba_mem_web0_o, mba_mem_wmask0_o}, 32'd0);
    next_cycle();
    drive(1'b0, 15'h0, 1'b0, 1'b0, 4'h0, 15'h0, 32'd0);
    @(negedge clk);
    check("z_ack", {30'd0, instr_rvalid_o, data_rvalid_o}, 32'd1);
    check("z_mem", mem[9'h22], 32'hCAFEF00D);

    // Top of the address range passes straight through.
    next_cycle();
    drive(1'b1, 15'h7FFF, 1'b0, 1'b0, 4'h0, 15'h0, 32'd0);
    @(negedge clk);
    check("hi_addr0", mba_mem_addr0_o, 32'h1FFF);
    next_cycle();
    drive(1'b0, 15'h0, 1'b0, 1'b0, 4'h0, 15'h0, 32'd0);
    @(negedge clk);
    check("hi_rdata", instr_rdata_o, 32'h0F0F0F0F);

    // Reset asserted the cycle after an instr grant drops the response.
    next_cycle();
    drive(1'b1, 15'h0040, 1'b0, 1'b0, 4'h0, 15'h0, 32'd0);
    @(negedge clk);
    check("mr_gnt", {30'd0, instr_gnt_o, data_gnt_o}, 32'd2);
    next_cycle();
    rstn_i = 1'b0;
    drive(1'b0, 15'h0, 1'b0, 1'b0, 4'h0, 15'h0, 32'd0);
    @(negedge clk);
    check("mr_rv",   {30'd0, instr_rvalid_o, data_rvalid_o}, 32'd0);
    check("mr_rd",   instr_rdata_o, 32'd0);
    check("mr_csb0", {31'd0, mba_mem_csb0_o}, 32'd1);
    next_cycle();
    rstn_i = 1'b1;
    @(negedge clk);
    check("mr_post", {30'd0, instr_rvalid_o, data_rvalid_o}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
